// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default datapath width, register-address width
// and the MEM-stage access FSM encoding.
package pipe_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int RA_W       = 5;
  localparam int CNT_W      = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. When load is low the register captures a bubble
// (all fields zero, so nothing is written back).
module mem_wb_reg
  import pipe_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load,
  input  logic            reg_write,
  input  logic            mem2reg,
  input  logic [DW-1:0]   read_data,
  input  logic [DW-1:0]   alu_data,
  input  logic [RA_W-1:0] rd_addr,
  output logic            wb_reg_write,
  output logic            wb_mem2reg,
  output logic [DW-1:0]   wb_read_data,
  output logic [DW-1:0]   wb_alu_data,
  output logic [RA_W-1:0] wb_rd_addr
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_reg_write <= 1'b0;
      wb_mem2reg   <= 1'b0;
      wb_read_data <= '0;
      wb_alu_data  <= '0;
      wb_rd_addr   <= '0;
    end else if (load) begin
      wb_reg_write <= reg_write;
      wb_mem2reg   <= mem2reg;
      wb_read_data <= read_data;
      wb_alu_data  <= alu_data;
      wb_rd_addr   <= rd_addr;
    end else begin
      wb_reg_write <= 1'b0;
      wb_mem2reg   <= 1'b0;
      wb_read_data <= '0;
      wb_alu_data  <= '0;
      wb_rd_addr   <= '0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls the front of the
// pipeline until ack or timeout, resolves branches and feeds MEM/WB.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int DW      = DW_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            RegWrite_i,
  input  logic            MemWrite_i,
  input  logic            MemRead_i,
  input  logic            Mem2Reg_i,
  input  logic            Branch_i,
  input  logic [DW-1:0]   AddResult_i,
  input  logic            Zero_i,
  input  logic [DW-1:0]   ALU_data_i,
  input  logic [DW-1:0]   writeData_i,
  input  logic [4:0]      RDaddr_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [DW-1:0]   dmem_addr_o,
  output logic [DW-1:0]   dmem_wdata_o,
  input  logic            dmem_ack_i,
  input  logic [DW-1:0]   dmem_rdata_i,
  output logic            stall_o,
  output logic            PCSrc_o,
  output logic [DW-1:0]   BranchTarget_o,
  output logic            RegWrite_o,
  output logic            Mem2Reg_o,
  output logic [DW-1:0]   ReadData_o,
  output logic [DW-1:0]   ALU_data_o,
  output logic [4:0]      RDaddr_o,
  output logic            timeout_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                timeout_q;
  logic                req_we_q;
  logic [DW-1:0]       req_addr_q, req_wdata_q;
  logic                mem_op, ack_take, to_hit, wb_load;

  assign mem_op = MemRead_i | MemWrite_i;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    stall_o      = 1'b0;
    ack_take     = 1'b0;
    to_hit       = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (mem_op) begin
            dmem_req_o   = 1'b1;
            dmem_we_o    = MemWrite_i;
            dmem_addr_o  = ALU_data_i;
            dmem_wdata_o = writeData_i;
            stall_o      = 1'b1;
            state_d      = WAIT;
          end
        end
        WAIT: begin
          // Request fields come from the copy taken at issue, not the inputs.
          dmem_req_o   = 1'b1;
          dmem_we_o    = req_we_q;
          dmem_addr_o  = req_addr_q;
          dmem_wdata_o = req_wdata_q;
          if (dmem_ack_i) begin
            ack_take = 1'b1;
            state_d  = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            to_hit  = 1'b1;
            state_d = IDLE;
          end else begin
            stall_o = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign wb_load        = !stall_o && !to_hit;
  assign PCSrc_o        = Branch_i & Zero_i & ~stall_o & ~rst_i;
  assign BranchTarget_o = rst_i ? '0 : AddResult_i;
  assign timeout_o      = timeout_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT && state_d == WAIT) cnt_q <= cnt_q + 1'b1;
      else                                    cnt_q <= '0;
      if (to_hit) timeout_q <= 1'b1;
      if (state_q == IDLE && mem_op) begin
        req_we_q    <= MemWrite_i;
        req_addr_q  <= ALU_data_i;
        req_wdata_q <= writeData_i;
      end
    end
  end

  mem_wb_reg #(.DW(DW)) u_mem_wb (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load         (wb_load),
    .reg_write    (RegWrite_i),
    .mem2reg      (Mem2Reg_i),
    .read_data    (ack_take ? dmem_rdata_i : '0),
    .alu_data     (ALU_data_i),
    .rd_addr      (RDaddr_i),
    .wb_reg_write (RegWrite_o),
    .wb_mem2reg   (Mem2Reg_o),
    .wb_read_data (ReadData_o),
    .wb_alu_data  (ALU_data_o),
    .wb_rd_addr   (RDaddr_o)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load, store, branch, pass-through, spurious
// ack, timeout, back-to-back loads and reset in the middle of an access.
module tb_mem_stage;

  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          RegWrite_i, MemWrite_i, MemRead_i, Mem2Reg_i, Branch_i, Zero_i;
  logic [DW-1:0] AddResult_i, ALU_data_i, writeData_i, dmem_rdata_i;
  logic [4:0]    RDaddr_i;
  logic          dmem_ack_i;
  logic          dmem_req_o, dmem_we_o, stall_o, PCSrc_o, RegWrite_o, Mem2Reg_o, timeout_o;
  logic [DW-1:0] dmem_addr_o, dmem_wdata_o, BranchTarget_o, ReadData_o, ALU_data_o;
  logic [4:0]    RDaddr_o;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_i = ~clk_i;

  mem_stage #(.TIMEOUT(15), .DW(DW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .RegWrite_i     (RegWrite_i),
    .MemWrite_i     (MemWrite_i),
    .MemRead_i      (MemRead_i),
    .Mem2Reg_i      (Mem2Reg_i),
    .Branch_i       (Branch_i),
    .AddResult_i    (AddResult_i),
    .Zero_i         (Zero_i),
    .ALU_data_i     (ALU_data_i),
    .writeData_i    (writeData_i),
    .RDaddr_i       (RDaddr_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_ack_i     (dmem_ack_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .stall_o        (stall_o),
    .PCSrc_o        (PCSrc_o),
    .BranchTarget_o (BranchTarget_o),
    .RegWrite_o     (RegWrite_o),
    .Mem2Reg_o      (Mem2Reg_o),
    .ReadData_o     (ReadData_o),
    .ALU_data_o     (ALU_data_o),
    .RDaddr_o       (RDaddr_o),
    .timeout_o      (timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    RegWrite_i = 0; MemWrite_i = 0; MemRead_i = 0; Mem2Reg_i = 0;
    Branch_i = 0; Zero_i = 0; AddResult_i = '0; ALU_data_i = '0;
    writeData_i = '0; RDaddr_i = '0; dmem_ack_i = 0; dmem_rdata_i = '0;
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;

    // Reset: outputs forced low even with active inputs.
    MemRead_i = 1; Branch_i = 1; Zero_i = 1; AddResult_i = 32'h55;
    #2;
    check("rst_req", dmem_req_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_pcsrc", PCSrc_o, 0);
    check("rst_btgt", BranchTarget_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_regwrite", RegWrite_o, 0);
    tick(); tick();
    clear_inputs();
    rst_i = 1'b0;
    tick();

    // Load, ack on the third WAIT cycle.
    MemRead_i = 1; ALU_data_i = 32'h40; RDaddr_i = 5'd5; RegWrite_i = 1; Mem2Reg_i = 1;
    Branch_i = 1; Zero_i = 1;
    #1;
    check("ld_req", dmem_req_o, 1);
    check("ld_we", dmem_we_o, 0);
    check("ld_addr", dmem_addr_o, 32'h40);
    check("ld_stall0", stall_o, 1);
    check("ld_pcsrc_gated", PCSrc_o, 0);
    tick();
    Branch_i = 0; Zero_i = 0;
    #1;
    check("ld_stall1", stall_o, 1);
    check("ld_req1", dmem_req_o, 1);
    check("ld_bubble", RegWrite_o, 0);
    tick();
    #1;
    check("ld_stall2", stall_o, 1);
    tick();
    dmem_ack_i = 1; dmem_rdata_i = 32'hDEADBEEF;
    #1;
    check("ld_ack_stall", stall_o, 0);
    check("ld_ack_addr", dmem_addr_o, 32'h40);
    tick();
    clear_inputs();
    #1;
    check("ld_rdata", ReadData_o, 32'hDEADBEEF);
    check("ld_rdaddr", RDaddr_o, 5);
    check("ld_regwrite", RegWrite_o, 1);
    check("ld_mem2reg", Mem2Reg_o, 1);
    check("ld_aludata", ALU_data_o, 32'h40);
    check("ld_idle_req", dmem_req_o, 0);

    // Store (with read also set: write wins), ack on first WAIT cycle.
    MemWrite_i = 1; MemRead_i = 1; ALU_data_i = 32'h80; writeData_i = 32'h12345678;
    #1;
    check("st_we0", dmem_we_o, 1);
    check("st_stall0", stall_o, 1);
    check("st_wdata0", dmem_wdata_o, 32'h12345678);
    tick();
    dmem_ack_i = 1;
    #1;
    check("st_we1", dmem_we_o, 1);
    check("st_addr1", dmem_addr_o, 32'h80);
    check("st_wdata1", dmem_wdata_o, 32'h12345678);
    check("st_stall1", stall_o, 0);
    tick();
    clear_inputs();
    #1;
    check("st_regwrite", RegWrite_o, 0);
    check("st_idle_stall", stall_o, 0);

    // Branch taken / not taken, no memory access.
    Branch_i = 1; Zero_i = 1; AddResult_i = 32'h100;
    #1;
    check("br_pcsrc", PCSrc_o, 1);
    check("br_target", BranchTarget_o, 32'h100);
    check("br_stall", stall_o, 0);
    Zero_i = 0;
    #1;
    check("br_nottaken", PCSrc_o, 0);
    clear_inputs();

    // ALU op pass-through with a spurious ack in IDLE.
    RegWrite_i = 1; ALU_data_i = 32'h77; RDaddr_i = 5'd9;
    dmem_ack_i = 1; dmem_rdata_i = 32'hBAD;
    #1;
    check("sp_req", dmem_req_o, 0);
    check("sp_stall", stall_o, 0);
    tick();
    clear_inputs();
    #1;
    check("pt_regwrite", RegWrite_o, 1);
    check("pt_aludata", ALU_data_o, 32'h77);
    check("pt_rdaddr", RDaddr_o, 9);
    check("sp_rdata", ReadData_o, 0);
    check("sp_state_idle", dmem_req_o, 0);

    // Timeout: no ack at all.
    MemRead_i = 1; ALU_data_i = 32'h200; RegWrite_i = 1; RDaddr_i = 5'd3;
    #1;
    check("to_stall0", stall_o, 1);
    tick();
    for (int i = 1; i <= 14; i++) begin
      check($sformatf("to_stall_w%0d", i), stall_o, 1);
      check($sformatf("to_flag_w%0d", i), timeout_o, 0);
      tick();
    end
    check("to_release", stall_o, 0);
    tick();
    clear_inputs();
    #1;
    check("to_flag", timeout_o, 1);
    check("to_bubble", RegWrite_o, 0);
    check("to_idle_req", dmem_req_o, 0);
    tick();
    check("to_sticky", timeout_o, 1);

    // Back-to-back loads, each acked on the first WAIT cycle.
    MemRead_i = 1; ALU_data_i = 32'h10; RDaddr_i = 5'd1; RegWrite_i = 1; Mem2Reg_i = 1;
    #1;
    check("bb1_req", dmem_req_o, 1);
    tick();
    dmem_ack_i = 1; dmem_rdata_i = 32'h1111;
    #1;
    check("bb1_ack_stall", stall_o, 0);
    tick();
    dmem_ack_i = 0; dmem_rdata_i = '0; ALU_data_i = 32'h14; RDaddr_i = 5'd2;
    #1;
    check("bb2_req", dmem_req_o, 1);
    check("bb2_addr", dmem_addr_o, 32'h14);
    check("bb2_stall", stall_o, 1);
    check("bb1_rdata", ReadData_o, 32'h1111);
    check("bb1_rdaddr", RDaddr_o, 1);
    check("bb1_regwrite", RegWrite_o, 1);
    tick();
    dmem_ack_i = 1; dmem_rdata_i = 32'h2222;
    #1;
    check("bb2_ack_stall", stall_o, 0);
    check("bb2_bubble", RegWrite_o, 0);
    tick();
    clear_inputs();
    #1;
    check("bb2_rdata", ReadData_o, 32'h2222);
    check("bb2_rdaddr", RDaddr_o, 2);
    check("bb2_regwrite", RegWrite_o, 1);

    // Reset on the 2nd WAIT cycle, late ack afterwards.
    MemRead_i = 1; ALU_data_i = 32'h300; RegWrite_i = 1; RDaddr_i = 5'd7;
    tick();
    tick();
    rst_i = 1'b1;
    #1;
    check("mr_req", dmem_req_o, 0);
    check("mr_stall", stall_o, 0);
    check("mr_timeout", timeout_o, 0);
    check("mr_regwrite", RegWrite_o, 0);
    check("mr_addr", dmem_addr_o, 0);
    tick();
    rst_i = 1'b0;
    clear_inputs();
    dmem_ack_i = 1; dmem_rdata_i = 32'hCAFE;
    #1;
    check("mr_late_req", dmem_req_o, 0);
    check("mr_late_stall", stall_o, 0);
    tick();
    clear_inputs();
    #1;
    check("mr_late_rdata", ReadData_o, 0);
    check("mr_late_regwrite", RegWrite_o, 0);
    check("mr_late_timeout", timeout_o, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
